// File: rtl/fetch_queue.sv
// Instruction-fetch front end: keeps several SRAM requests in flight and queues in-order
// responses for decode; redirects flush the queue and discard responses still in flight.
module fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_ready,
  input  logic        inst_sram_rvalid,
  input  logic [31:0] inst_sram_rdata,
  input  logic        inst_sram_addressError,
  input  logic        inst_sram_tlb_miss,
  input  logic        inst_sram_tlb_invalid,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  output logic        inst_addressError,
  output logic        inst_tlb_miss,
  output logic        inst_tlb_invalid
);
  localparam int QW = $clog2(DEPTH);
  localparam int CW = QW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int RW = ((CW > OW) ? CW : OW) + 1;

  logic          run_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          halt_q, halt_d;
  logic [OW-1:0] live_q, live_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [TW-1:0] tag_wr_q, tag_wr_d;
  logic [TW-1:0] tag_rd_q, tag_rd_d;
  logic [QW-1:0] head_q, head_d;
  logic [QW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] tag_mem [MAX_OUTSTANDING];
  logic [31:0] q_pc    [DEPTH];
  logic [31:0] q_data  [DEPTH];
  logic [2:0]  q_flt   [DEPTH];

  logic [OW:0]   inflight;
  logic [RW-1:0] reserved;
  logic          aligned, accept, rsp_keep, mis_push, push, pop;
  logic [31:0]   push_pc, push_data;
  logic [2:0]    push_flt;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  // Queue slots are reserved at issue time (count + live), so a kept response always has room.
  always_comb begin
    inflight      = (OW+1)'(live_q) + (OW+1)'(drop_q);
    reserved      = RW'(cnt_q) + RW'(live_q);
    aligned       = (fetch_pc_q[1:0] == 2'b00);
    inst_sram_req = run_q && !halt_q && !redirect_valid && aligned
                    && (inflight < (OW+1)'(MAX_OUTSTANDING))
                    && (reserved < RW'(DEPTH));
    accept        = inst_sram_req && inst_sram_ready;
    rsp_keep      = inst_sram_rvalid && (drop_q == '0) && (live_q != '0);
    mis_push      = run_q && !halt_q && !aligned && (live_q == '0)
                    && (cnt_q != CW'(DEPTH)) && !redirect_valid;
    push          = (rsp_keep && !redirect_valid) || mis_push;
    pop           = inst_valid && inst_ready;
    push_pc       = rsp_keep ? tag_mem[tag_rd_q] : fetch_pc_q;
    push_data     = rsp_keep ? inst_sram_rdata : 32'h0;
    push_flt      = rsp_keep ? {inst_sram_addressError, inst_sram_tlb_miss, inst_sram_tlb_invalid}
                             : 3'b100;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    halt_d     = halt_q;
    live_d     = live_q;
    drop_d     = drop_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    if (redirect_valid) begin
      // Everything still in flight becomes a discard; one arriving right now is already gone.
      fetch_pc_d = redirect_pc;
      halt_d     = 1'b0;
      drop_d     = OW'(inflight - ((inst_sram_rvalid && (inflight != '0)) ? (OW+1)'(1) : '0));
      live_d     = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      head_d     = '0;
      tail_d     = '0;
      cnt_d      = '0;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_wr_d   = tag_next(tag_wr_q);
      end
      if (rsp_keep) tag_rd_d = tag_next(tag_rd_q);
      if (inst_sram_rvalid && (drop_q != '0)) drop_d = drop_q - OW'(1);
      live_d = live_q + OW'(accept) - OW'(rsp_keep);
      if (push) tail_d = tail_q + QW'(1);
      if (pop) head_d = head_q + QW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (push && (push_flt != 3'b000)) halt_d = 1'b1;
    end
  end

  // run_q holds off the first request until the cycle after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      halt_q     <= 1'b0;
      live_q     <= '0;
      drop_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      halt_q     <= halt_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr_q] <= fetch_pc_q;
    if (push) begin
      q_pc[tail_q]   <= push_pc;
      q_data[tail_q] <= push_data;
      q_flt[tail_q]  <= push_flt;
    end
  end

  assign inst_valid     = (cnt_q != '0);
  assign inst_sram_addr = inst_sram_req ? fetch_pc_q : 32'h0;
  assign inst_pc        = inst_valid ? q_pc[head_q] : 32'h0;
  assign inst_data      = inst_valid ? q_data[head_q] : 32'h0;
  assign {inst_addressError, inst_tlb_miss, inst_tlb_invalid} = inst_valid ? q_flt[head_q] : 3'b000;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: SRAM responder plus a per-redirect sequential-stream model of what
// decode must receive; directed scenarios followed by a randomized stretch.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_ready = 1'b0;
  logic        inst_sram_rvalid = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        inst_sram_addressError = 1'b0;
  logic        inst_sram_tlb_miss = 1'b0;
  logic        inst_sram_tlb_invalid = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_addressError;
  logic        inst_tlb_miss;
  logic        inst_tlb_invalid;

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk(clk), .resetn(resetn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_ready(inst_sram_ready), .inst_sram_rvalid(inst_sram_rvalid),
    .inst_sram_rdata(inst_sram_rdata), .inst_sram_addressError(inst_sram_addressError),
    .inst_sram_tlb_miss(inst_sram_tlb_miss), .inst_sram_tlb_invalid(inst_sram_tlb_invalid),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc), .inst_data(inst_data),
    .inst_addressError(inst_addressError), .inst_tlb_miss(inst_tlb_miss),
    .inst_tlb_invalid(inst_tlb_invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  req_t pend[$];

  // Expected decode stream for the current redirect target.
  int          ep = 0;
  logic [31:0] exp_pc, next_req;
  bit          ep_mis, seen_fault, req_halt;
  int          after_left;
  int          acc_cnt = 0, hs_cnt = 0;
  int          first_acc = -1, first_val = -1;

  int lat_min = 1, lat_max = 1, rv_hold = 0;
  logic [31:0] force_addr = 32'h0040_0008;
  logic [2:0]  force_flt  = 3'b010;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [2:0] flt_of(input logic [31:0] a);
    if (a == force_addr) return force_flt;
    if (a[31:16] != 16'h0041) return 3'b000;
    case (a[7:2])
      6'h2B:   return 3'b100;
      6'h11:   return 3'b010;
      6'h07:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic new_epoch(input logic [31:0] pc);
    ep++;
    exp_pc     = pc;
    next_req   = pc;
    ep_mis     = (pc[1:0] != 2'b00);
    seen_fault = 1'b0;
    req_halt   = 1'b0;
    after_left = 0;
  endtask

  task automatic model_pop();
    logic [31:0] e_data;
    logic [2:0]  e_flt;
    if (seen_fault && after_left == 0) begin
      chk("extra_entry", 32'(inst_valid), 32'h0);
      return;
    end
    if (ep_mis) begin
      e_data = 32'h0;
      e_flt  = 3'b100;
    end else begin
      e_data = data_of(exp_pc);
      e_flt  = flt_of(exp_pc);
    end
    chk("head_pc", inst_pc, exp_pc);
    chk("head_data", inst_data, e_data);
    chk("head_flags", 32'({inst_addressError, inst_tlb_miss, inst_tlb_invalid}), 32'(e_flt));
    if (seen_fault) after_left--;
    else if (e_flt != 3'b000) begin
      seen_fault = 1'b1;
      after_left = ep_mis ? 0 : MAXO - 1;
    end
    exp_pc += 32'd4;
  endtask

  task automatic drive_rsp();
    inst_sram_rvalid = 1'b0;
    inst_sram_rdata  = 32'h0;
    {inst_sram_addressError, inst_sram_tlb_miss, inst_sram_tlb_invalid} = 3'b000;
    if (pend.size() > 0 && pend[0].due <= cyc && int'($urandom_range(99, 0)) >= rv_hold) begin
      inst_sram_rvalid = 1'b1;
      inst_sram_rdata  = data_of(pend[0].addr);
      {inst_sram_addressError, inst_sram_tlb_miss, inst_sram_tlb_invalid} = flt_of(pend[0].addr);
    end
  endtask

  // One clock: observe mid-cycle, update the model, advance, then drive the responder.
  task automatic step();
    req_t r;
    @(negedge clk);
    if (redirect_valid) chk("req_during_redirect", 32'(inst_sram_req), 32'h0);
    if (inst_sram_req && inst_sram_ready) begin
      chk("inflight_bound", 32'(pend.size() < MAXO), 32'h1);
      chk("req_addr", inst_sram_addr, next_req);
      chk("req_aligned", 32'(inst_sram_addr[1:0]), 32'h0);
      chk("req_after_fault", 32'(req_halt), 32'h0);
      r.addr = inst_sram_addr;
      r.due  = cyc + int'($urandom_range(lat_max, lat_min));
      r.ep   = ep;
      pend.push_back(r);
      next_req += 32'd4;
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (inst_valid && first_val < 0) first_val = cyc;
    if (inst_valid && inst_ready) begin
      model_pop();
      hs_cnt++;
    end
    if (inst_sram_rvalid && pend.size() > 0) begin
      r = pend.pop_front();
      if (r.ep == ep && !redirect_valid && flt_of(r.addr) != 3'b000) req_halt = 1'b1;
    end
    if (redirect_valid) new_epoch(redirect_pc);
    @(posedge clk);
    #1;
    cyc++;
    drive_rsp();
  endtask

  task automatic apply_reset();
    resetn           = 1'b0;
    redirect_valid   = 1'b0;
    inst_sram_rvalid = 1'b0;
    #1;
    chk("rst_req", 32'(inst_sram_req), 32'h0);
    chk("rst_addr", inst_sram_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_flags", 32'({inst_addressError, inst_tlb_miss, inst_tlb_invalid}), 32'h0);
    pend.delete();
    new_epoch(RPC);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc = 0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int a0, h0, k;
    @(posedge clk);
    #1;
    apply_reset();

    // Stall decode from reset release: reservation caps issue at DEPTH, head held.
    inst_ready = 1'b0;
    inst_sram_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (inst_valid) chk("head_stable", inst_pc, RPC);
    end
    chk("first_req_cycle", 32'(first_acc), 32'd1);
    chk("first_valid_cycle", 32'(first_val), 32'd3);
    chk("stall_accepts", 32'(acc_cnt), 32'(DEPTH));
    chk("stall_req_low", 32'(inst_sram_req), 32'h0);
    chk("stall_head_data", inst_data, data_of(RPC));
    inst_ready = 1'b1;
    h0 = hs_cnt;
    repeat (4) step();
    chk("drain_pops", 32'(hs_cnt - h0), 32'd4);
    a0 = acc_cnt;
    repeat (10) step();
    chk("fetch_resumes", 32'(acc_cnt > a0 + 4), 32'h1);

    // Redirect with two requests in flight.
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 20 && pend.size() != 2; i++) step();
    chk("two_inflight", 32'(pend.size()), 32'd2);
    redirect_to(32'h8000_0180);
    chk("redir_queue_empty", 32'(inst_valid), 32'h0);
    lat_min = 1; lat_max = 1;
    h0 = hs_cnt;
    repeat (15) step();
    chk("redir_progress", 32'(hs_cnt > h0), 32'h1);

    // TLB refill fault at 00400008 halts issue.
    redirect_to(32'h0040_0000);
    repeat (12) step();
    chk("tlb_entry_seen", 32'(seen_fault), 32'h1);
    a0 = acc_cnt;
    repeat (10) step();
    chk("halt_no_req", 32'(acc_cnt - a0), 32'h0);
    chk("halt_queue_empty", 32'(inst_valid), 32'h0);
    redirect_to(32'h8000_0000);
    a0 = acc_cnt;
    repeat (10) step();
    chk("halt_cleared", 32'(acc_cnt > a0), 32'h1);

    // Misaligned redirect: one address-error entry, no requests.
    redirect_to(32'h0040_0002);
    a0 = acc_cnt;
    h0 = hs_cnt;
    repeat (10) step();
    chk("mis_no_req", 32'(acc_cnt - a0), 32'h0);
    chk("mis_one_entry", 32'(hs_cnt - h0), 32'd1);
    chk("mis_flag_seen", 32'(seen_fault), 32'h1);

    // Reset with two requests outstanding.
    redirect_to(32'hBFC0_0100);
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 20 && pend.size() != 2; i++) step();
    chk("rst_two_inflight", 32'(pend.size()), 32'd2);
    apply_reset();
    lat_min = 1; lat_max = 1;
    h0 = hs_cnt;
    repeat (15) step();
    chk("rst_restart", 32'(hs_cnt > h0), 32'h1);

    // Randomized traffic with redirects, stalls and faults.
    lat_min = 1; lat_max = 3; rv_hold = 20;
    h0 = hs_cnt;
    for (int i = 0; i < 3000; i++) begin
      inst_ready      = ($urandom_range(99, 0) < 70);
      inst_sram_ready = ($urandom_range(99, 0) < 65);
      if ($urandom_range(99, 0) < 4) begin
        k = int'($urandom_range(63, 0));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0041_0000 + 32'(k * 4);
        if ($urandom_range(9, 0) == 0) redirect_pc += 32'($urandom_range(3, 1));
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    repeat (10) step();
    chk("random_traffic", 32'(hs_cnt > h0 + 200), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
